// File: rtl/vp_tag_decoder.sv
// Receive-side monitor for the per-frame tag the sensor path stamps into the first
// TAG_PIXELS pixels of every active line: checks line/frame consistency and frame continuity.
module vp_tag_decoder #(
    parameter int TAG_PIXELS = 20,
    parameter int DATA_W     = 10,
    parameter int CNT_W      = 16
) (
    input  logic              vpclkin,
    input  logic              nReset,
    input  logic [DATA_W-1:0] vpdin,
    input  logic              href,
    input  logic              vsync,
    output logic              frame_done,
    output logic [7:0]        frame_tag,
    output logic              frame_tag_ok,
    output logic              frame_drop,
    output logic [11:0]       line_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic [CNT_W-1:0]  err_count
);

    typedef enum logic [1:0] {SYNC, WAIT_LINE, TAG, PAYLOAD} state_t;

    localparam logic [7:0] TAG_LAST = 8'(TAG_PIXELS);

    state_t            state, state_n;
    logic              href_q, href_q2, vsync_q, vsync_q2;
    logic [DATA_W-1:0] vpdin_q;
    logic [7:0]        pix_cnt, pix_cnt_n;
    logic [7:0]        line_tag, line_tag_n;
    logic              line_bad, line_bad_n;

    logic [7:0]        frame_tag_int, frame_tag_c;
    logic              frame_err, frame_err_c;
    logic [11:0]       line_count_int, line_count_c;
    logic [7:0]        prev_tag;
    logic              have_prev;

    logic              href_rise, vsync_rise, frame_end, frame_ok;
    logic              close_line, close_bad, err_inc;
    logic [7:0]        pix_tag, diff;
    logic              pix_low_bad;
    logic [CNT_W:0]    drop_sum;

    assign href_rise   = href_q & ~href_q2;
    assign vsync_rise  = vsync_q & ~vsync_q2;
    assign frame_end   = vsync_rise && (state != SYNC);
    assign pix_tag     = vpdin_q[DATA_W-1 -: 8];
    assign pix_low_bad = |vpdin_q[DATA_W-9:0];

    always_ff @(posedge vpclkin or negedge nReset) begin
        if (!nReset) begin
            href_q   <= 1'b0;
            href_q2  <= 1'b0;
            vsync_q  <= 1'b0;
            vsync_q2 <= 1'b0;
            vpdin_q  <= '0;
            state    <= SYNC;
            pix_cnt  <= '0;
            line_tag <= '0;
            line_bad <= 1'b0;
        end else begin
            href_q   <= href;
            href_q2  <= href_q;
            vsync_q  <= vsync;
            vsync_q2 <= vsync_q;
            vpdin_q  <= vpdin;
            state    <= state_n;
            pix_cnt  <= pix_cnt_n;
            line_tag <= line_tag_n;
            line_bad <= line_bad_n;
        end
    end

    // A vsync edge closes any open line; inside TAG that line never finished its tag, so it is bad.
    always_comb begin
        state_n    = state;
        pix_cnt_n  = pix_cnt;
        line_tag_n = line_tag;
        line_bad_n = line_bad;
        close_line = 1'b0;
        close_bad  = line_bad;
        case (state)
            SYNC: begin
                if (vsync_rise)
                    state_n = WAIT_LINE;
            end
            WAIT_LINE: begin
                if (href_rise && !vsync_q) begin
                    pix_cnt_n  = 8'd1;
                    line_tag_n = pix_tag;
                    line_bad_n = pix_low_bad;
                    state_n    = (TAG_PIXELS == 1) ? PAYLOAD : TAG;
                end
            end
            TAG: begin
                if (vsync_rise || !href_q) begin
                    close_line = 1'b1;
                    close_bad  = 1'b1;
                    state_n    = WAIT_LINE;
                end else begin
                    if (pix_tag != line_tag || pix_low_bad)
                        line_bad_n = 1'b1;
                    pix_cnt_n = pix_cnt + 8'd1;
                    if (pix_cnt_n == TAG_LAST)
                        state_n = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (vsync_rise || !href_q) begin
                    close_line = 1'b1;
                    state_n    = WAIT_LINE;
                end
            end
            default: state_n = SYNC;
        endcase
    end

    // Frame accumulators with the closing line folded in, so a frame end sees its last line.
    always_comb begin
        line_count_c = line_count_int;
        frame_tag_c  = frame_tag_int;
        frame_err_c  = frame_err;
        err_inc      = 1'b0;
        if (close_line) begin
            if (line_count_int != 12'hFFF)
                line_count_c = line_count_int + 12'd1;
            if (line_count_int == 12'd0)
                frame_tag_c = line_tag;
            else if (line_tag != frame_tag_int)
                frame_err_c = 1'b1;
            if (close_bad) begin
                frame_err_c = 1'b1;
                err_inc     = 1'b1;
            end
        end
    end

    assign frame_ok = (line_count_c != 12'd0) && !frame_err_c;
    assign diff     = frame_tag_c - prev_tag - 8'd1;
    assign drop_sum = {1'b0, drop_count} + {{(CNT_W-7){1'b0}}, diff};

    always_ff @(posedge vpclkin or negedge nReset) begin
        if (!nReset) begin
            frame_done     <= 1'b0;
            frame_tag      <= '0;
            frame_tag_ok   <= 1'b0;
            frame_drop     <= 1'b0;
            line_count     <= '0;
            drop_count     <= '0;
            err_count      <= '0;
            frame_tag_int  <= '0;
            frame_err      <= 1'b0;
            line_count_int <= '0;
            prev_tag       <= '0;
            have_prev      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_drop <= 1'b0;
            if (err_inc && err_count != '1)
                err_count <= err_count + CNT_W'(1);
            if (frame_end) begin
                frame_done     <= 1'b1;
                frame_tag      <= frame_tag_c;
                line_count     <= line_count_c;
                frame_tag_ok   <= frame_ok;
                frame_tag_int  <= '0;
                frame_err      <= 1'b0;
                line_count_int <= '0;
                if (frame_ok) begin
                    prev_tag  <= frame_tag_c;
                    have_prev <= 1'b1;
                    if (have_prev && diff != 8'd0) begin
                        frame_drop <= 1'b1;
                        drop_count <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
                    end
                end
            end else begin
                frame_tag_int  <= frame_tag_c;
                frame_err      <= frame_err_c;
                line_count_int <= line_count_c;
            end
        end
    end

endmodule
